// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit decoder.
// Line-state encodings, stream-status codes and decoder FSM states.
package usb_rx_pkg;

    localparam logic [1:0] SE0  = 2'b00;
    localparam logic [1:0] FS_J = 2'b10;
    localparam logic [1:0] LS_J = 2'b01;

    typedef enum logic [2:0] {
        RxStData     = 3'd0,
        RxStStart    = 3'd1,
        RxStEnd      = 3'd2,
        RxStStuffErr = 3'd3,
        RxStAlignErr = 3'd4,
        RxStAbort    = 3'd5
    } rx_status_e;

    typedef enum logic [2:0] {
        StWaitJ,
        StIdle,
        StSync,
        StData,
        StEop
    } rx_state_e;

endpackage

// File: rtl/usb_rx_out_hold.sv
// One-entry valid/ready holding register for decoded bytes and status.
// A load while full overwrites the held item; ready is registered.
module usb_rx_out_hold
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  rx_status_e status_i,
    input  logic       rdy_i,
    output logic       rdy_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    output rx_status_e status_o
);

    logic       valid_q, valid_d;
    logic       rdy_q;
    logic [7:0] data_q, data_d;
    rx_status_e status_q, status_d;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        status_d = status_q;
        if (valid_q && rdy_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d  = 1'b1;
            data_d   = data_i;
            status_d = status_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= 8'h00;
            status_q <= RxStData;
        end else begin
            valid_q  <= valid_d;
            rdy_q    <= ~valid_q;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign rdy_o    = rdy_q;
    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign status_o = status_q;

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, SYNC hunt, unstuffing and EOP detection.
// Optional error counters are enabled with USB_RX_ERR_CNT_EN.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedRate,
    input  logic [1:0] RxBitsIn,
    input  logic       RxWEnIn,
    input  logic       RxWireActiveIn,
`ifdef USB_RX_ERR_CNT_EN
    output logic [7:0] stuffErrCnt,
    output logic [7:0] alignErrCnt,
    input  logic       errCntClr,
`endif
    output logic       RxRdyOut,
    output logic [7:0] RxDataOut,
    output logic [2:0] RxStatusOut,
    output logic       RxDataValid,
    input  logic       RxDataRdyIn,
    output logic       RxPktActive
);

    localparam logic [2:0] SyncMinZ = 3'(SYNC_MIN_ZEROS);

    rx_state_e  state_q, state_d;
    logic       prev_j_q, prev_j_d;
    logic [2:0] zero_cnt_q, zero_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       pkt_active_q, pkt_active_d;

    logic       emit;
    rx_status_e emit_status;
    logic [7:0] emit_data;
    logic [1:0] j_level, k_level;
    logic       is_se0, is_j, is_k, dec_bit;
    logic [7:0] shifted;
    rx_status_e status_w;

    assign j_level = fullSpeedRate ? FS_J : LS_J;
    assign k_level = ~j_level;
    assign is_se0  = (RxBitsIn == SE0);
    assign is_j    = (RxBitsIn == j_level);
    assign is_k    = (RxBitsIn == k_level);
    assign dec_bit = (is_j == prev_j_q);
    assign shifted = {dec_bit, byte_q[7:1]};

    always_comb begin
        state_d      = state_q;
        prev_j_d     = prev_j_q;
        zero_cnt_d   = zero_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        byte_d       = byte_q;
        pkt_active_d = pkt_active_q;
        emit         = 1'b0;
        emit_status  = RxStData;
        emit_data    = byte_q;

        if (RxWEnIn) begin
            if (is_j || is_k) begin
                prev_j_d = is_j;
            end
            // Loss of wire activity aborts before any symbol decode.
            if (!RxWireActiveIn && state_q inside {StSync, StData, StEop}) begin
                emit        = 1'b1;
                emit_status = RxStAbort;
                state_d     = StWaitJ;
            end else begin
                unique case (state_q)
                    StWaitJ: begin
                        if (is_j) begin
                            state_d  = StIdle;
                            prev_j_d = 1'b1;
                        end
                    end
                    StIdle: begin
                        if (is_k) begin
                            state_d    = StSync;
                            zero_cnt_d = 3'd1;
                        end
                    end
                    StSync: begin
                        if (is_se0) begin
                            state_d = StWaitJ;
                        end else if (is_j || is_k) begin
                            if (!dec_bit) begin
                                zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
                            end else if (zero_cnt_q >= SyncMinZ) begin
                                emit        = 1'b1;
                                emit_status = RxStStart;
                                state_d     = StData;
                                bit_cnt_d   = 3'd0;
                                ones_cnt_d  = 3'd0;
                            end else begin
                                state_d  = StIdle;
                                prev_j_d = 1'b1;
                            end
                        end
                    end
                    StData: begin
                        if (is_se0) begin
                            state_d = StEop;
                        end else if (is_j || is_k) begin
                            if (ones_cnt_q == 3'd6) begin
                                if (!dec_bit) begin
                                    ones_cnt_d = 3'd0;
                                end else begin
                                    emit        = 1'b1;
                                    emit_status = RxStStuffErr;
                                    state_d     = StWaitJ;
                                end
                            end else begin
                                byte_d     = shifted;
                                bit_cnt_d  = bit_cnt_q + 3'd1;
                                ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                                if (bit_cnt_q == 3'd7) begin
                                    emit        = 1'b1;
                                    emit_status = RxStData;
                                    emit_data   = shifted;
                                end
                            end
                        end
                    end
                    StEop: begin
                        if (is_j) begin
                            emit        = 1'b1;
                            emit_status = (bit_cnt_q == 3'd0) ? RxStEnd : RxStAlignErr;
                            state_d     = StWaitJ;
                        end else if (is_k) begin
                            emit        = 1'b1;
                            emit_status = RxStAlignErr;
                            state_d     = StWaitJ;
                        end
                    end
                    default: state_d = StWaitJ;
                endcase
            end
        end

        if (emit) begin
            if (emit_status == RxStStart) begin
                pkt_active_d = 1'b1;
            end else if (emit_status != RxStData) begin
                pkt_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWaitJ;
            prev_j_q     <= 1'b1;
            zero_cnt_q   <= 3'd0;
            bit_cnt_q    <= 3'd0;
            ones_cnt_q   <= 3'd0;
            byte_q       <= 8'h00;
            pkt_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_j_q     <= prev_j_d;
            zero_cnt_q   <= zero_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            byte_q       <= byte_d;
            pkt_active_q <= pkt_active_d;
        end
    end

    usb_rx_out_hold u_out_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (emit),
        .data_i   (emit_data),
        .status_i (emit_status),
        .rdy_i    (RxDataRdyIn),
        .rdy_o    (RxRdyOut),
        .valid_o  (RxDataValid),
        .data_o   (RxDataOut),
        .status_o (status_w)
    );

    assign RxStatusOut = status_w;
    assign RxPktActive = pkt_active_q;

`ifdef USB_RX_ERR_CNT_EN
    logic [7:0] stuff_cnt_q, align_cnt_q;

    // Clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || errCntClr) begin
            stuff_cnt_q <= 8'h00;
            align_cnt_q <= 8'h00;
        end else if (emit) begin
            if (emit_status == RxStStuffErr && stuff_cnt_q != 8'hFF) begin
                stuff_cnt_q <= stuff_cnt_q + 8'h01;
            end
            if (emit_status == RxStAlignErr && align_cnt_q != 8'hFF) begin
                align_cnt_q <= align_cnt_q + 8'h01;
            end
        end
    end

    assign stuffErrCnt = stuff_cnt_q;
    assign alignErrCnt = align_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench for usb_rx_bit_decoder: a bench-side NRZI/stuffing encoder
// drives symbols and the expected item stream is matched against the output.
module tb_usb_rx_bit_decoder;

    localparam logic [2:0] EXP_DATA  = 3'd0;
    localparam logic [2:0] EXP_START = 3'd1;
    localparam logic [2:0] EXP_END   = 3'd2;
    localparam logic [2:0] EXP_STUFF = 3'd3;
    localparam logic [2:0] EXP_ALIGN = 3'd4;
    localparam logic [2:0] EXP_ABORT = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       fullSpeedRate;
    logic [1:0] RxBitsIn;
    logic       RxWEnIn;
    logic       RxWireActiveIn;
    logic       RxRdyOut;
    logic [7:0] RxDataOut;
    logic [2:0] RxStatusOut;
    logic       RxDataValid;
    logic       RxDataRdyIn;
    logic       RxPktActive;
`ifdef USB_RX_ERR_CNT_EN
    logic [7:0] stuffErrCnt, alignErrCnt;
    logic       errCntClr = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] d;
        logic       chk_d;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    lvl_j    = 1'b1;
    int    ones     = 0;

    always #5 clk = ~clk;

    usb_rx_bit_decoder #(.SYNC_MIN_ZEROS(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .fullSpeedRate  (fullSpeedRate),
        .RxBitsIn       (RxBitsIn),
        .RxWEnIn        (RxWEnIn),
        .RxWireActiveIn (RxWireActiveIn),
`ifdef USB_RX_ERR_CNT_EN
        .stuffErrCnt    (stuffErrCnt),
        .alignErrCnt    (alignErrCnt),
        .errCntClr      (errCntClr),
`endif
        .RxRdyOut       (RxRdyOut),
        .RxDataOut      (RxDataOut),
        .RxStatusOut    (RxStatusOut),
        .RxDataValid    (RxDataValid),
        .RxDataRdyIn    (RxDataRdyIn),
        .RxPktActive    (RxPktActive)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [7:0] d, input logic chk_d);
        item_t it;
        it.st    = st;
        it.d     = d;
        it.chk_d = chk_d;
        sb_q.push_back(it);
    endtask

    // Items are consumed on the negative edge before the accepting posedge.
    always @(negedge clk) begin
        if (!rst && RxDataValid && RxDataRdyIn) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_item", {29'd0, RxStatusOut}, 32'hFFFF_FFFF);
            end else begin
                item_t it;
                it = sb_q.pop_front();
                check_eq("item_status", {29'd0, RxStatusOut}, {29'd0, it.st});
                if (it.chk_d) begin
                    check_eq("item_data", {24'd0, RxDataOut}, {24'd0, it.d});
                end
            end
        end
    end

    function automatic logic [1:0] lvl_sym(input bit j);
        if (fullSpeedRate) return j ? 2'b10 : 2'b01;
        return j ? 2'b01 : 2'b10;
    endfunction

    task automatic send_sym(input logic [1:0] b, input logic act);
        RxBitsIn       = b;
        RxWireActiveIn = act;
        RxWEnIn        = 1'b1;
        @(posedge clk); #1;
        RxWEnIn        = 1'b0;
        RxWireActiveIn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_level(input bit j);
        lvl_j = j;
        send_sym(lvl_sym(j), 1'b1);
    endtask

    task automatic send_bit(input bit b);
        if (!b) lvl_j = ~lvl_j;
        send_sym(lvl_sym(lvl_j), 1'b1);
    endtask

    task automatic idle_j(input int n);
        repeat (n) send_level(1'b1);
    endtask

    task automatic send_sync();
        send_level(1'b0); send_level(1'b1); send_level(1'b0); send_level(1'b1);
        send_level(1'b0); send_level(1'b1); send_level(1'b0); send_level(1'b0);
        ones = 0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input bit stuff);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
            ones = v[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        send_sym(2'b00, 1'b1);
        send_sym(2'b00, 1'b1);
        send_level(1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        fullSpeedRate  = 1'b1;
        RxBitsIn       = 2'b10;
        RxWEnIn        = 1'b0;
        RxWireActiveIn = 1'b1;
        RxDataRdyIn    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdy", {31'd0, RxRdyOut}, 32'd0);
        check_eq("rst_valid", {31'd0, RxDataValid}, 32'd0);
        check_eq("rst_data", {24'd0, RxDataOut}, 32'd0);
        check_eq("rst_status", {29'd0, RxStatusOut}, 32'd0);
        check_eq("rst_pkt", {31'd0, RxPktActive}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rdy_after_rst", {31'd0, RxRdyOut}, 32'd1);

        // FS packet with 8'hA5.
        idle_j(3);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        check_eq("pkt_active_start", {31'd0, RxPktActive}, 32'd1);
        push_exp(EXP_DATA, 8'hA5, 1'b1);
        send_bits(8'hA5, 8, 1'b1);
        check_eq("pkt_active_data", {31'd0, RxPktActive}, 32'd1);
        push_exp(EXP_END, 8'h00, 1'b0);
        send_eop();
        check_eq("pkt_active_end", {31'd0, RxPktActive}, 32'd0);

        // 8'hFF requires a stuffed zero after the sixth one.
        idle_j(2);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        push_exp(EXP_DATA, 8'hFF, 1'b1);
        send_bits(8'hFF, 8, 1'b1);
        push_exp(EXP_END, 8'h00, 1'b0);
        send_eop();

        // Seven decoded ones with no stuffing.
        idle_j(2);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        push_exp(EXP_STUFF, 8'h00, 1'b0);
        send_bits(8'h7F, 7, 1'b0);
        check_eq("pkt_active_stuff", {31'd0, RxPktActive}, 32'd0);

        // EOP after 3 data bits.
        idle_j(2);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        send_bits(8'h05, 3, 1'b1);
        push_exp(EXP_ALIGN, 8'h00, 1'b0);
        send_eop();
        check_eq("pkt_active_align", {31'd0, RxPktActive}, 32'd0);

        // SYNC with 2 zeros is dropped; exactly 3 zeros is accepted.
        idle_j(2);
        send_level(1'b0); send_level(1'b1); send_level(1'b1);
        check_eq("short_sync_pkt", {31'd0, RxPktActive}, 32'd0);
        check_eq("short_sync_valid", {31'd0, RxDataValid}, 32'd0);
        idle_j(1);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_level(1'b0); send_level(1'b1); send_level(1'b0); send_level(1'b0);
        ones = 0;
        push_exp(EXP_DATA, 8'h81, 1'b1);
        send_bits(8'h81, 8, 1'b1);
        push_exp(EXP_END, 8'h00, 1'b0);
        send_eop();

        // Back-pressure after START, then abort mid-byte.
        idle_j(2);
        RxDataRdyIn = 1'b0;
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        check_eq("bp_valid", {31'd0, RxDataValid}, 32'd1);
        check_eq("bp_rdy_low", {31'd0, RxRdyOut}, 32'd0);
        RxDataRdyIn = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_rdy_still_low", {31'd0, RxRdyOut}, 32'd0);
        check_eq("bp_valid_clear", {31'd0, RxDataValid}, 32'd0);
        @(posedge clk); #1;
        check_eq("bp_rdy_back", {31'd0, RxRdyOut}, 32'd1);
        send_bits(8'hA5, 4, 1'b1);
        push_exp(EXP_ABORT, 8'h00, 1'b0);
        send_sym(lvl_sym(lvl_j), 1'b0);
        check_eq("pkt_active_abort", {31'd0, RxPktActive}, 32'd0);

        // Reset mid-packet discards the pending START.
        idle_j(2);
        RxDataRdyIn = 1'b0;
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        send_bits(8'h0F, 2, 1'b1);
        check_eq("pre_rst_pkt", {31'd0, RxPktActive}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        check_eq("mid_rst_valid", {31'd0, RxDataValid}, 32'd0);
        check_eq("mid_rst_rdy", {31'd0, RxRdyOut}, 32'd0);
        check_eq("mid_rst_pkt", {31'd0, RxPktActive}, 32'd0);
        check_eq("mid_rst_data", {24'd0, RxDataOut}, 32'd0);
        check_eq("mid_rst_status", {29'd0, RxStatusOut}, 32'd0);
        @(posedge clk); #1;
        check_eq("mid_rst_rdy_back", {31'd0, RxRdyOut}, 32'd1);
        RxDataRdyIn = 1'b1;

        // LS polarity packet.
        fullSpeedRate = 1'b0;
        idle_j(3);
        push_exp(EXP_START, 8'h00, 1'b0);
        send_sync();
        push_exp(EXP_DATA, 8'h3C, 1'b1);
        send_bits(8'h3C, 8, 1'b1);
        push_exp(EXP_END, 8'h00, 1'b0);
        send_eop();

        repeat (5) @(posedge clk);
        #1;
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
